controlador_ram_batch: RTL and testbench
========================================

CONTROLADOR_RAM_BATCH -- requirements
Module: controlador_ram_batch

Interface
REQ-001 Parameter DATA_W, default 16, operand word width in bits; RAM data width equals DATA_W.
REQ-002 Parameter ADDR_W, default 8, RAM address width, also width of pair count and progress count.
REQ-003 Parameter TIMEOUT, default 255, maximum cycles in ST_RB_WAIT_CALC before error; legal range 1..2^16-1.
REQ-004 clk_i  in  1  single clock; all logic on rising edge.
REQ-005 rst_i  in  1  reset, synchronous, active-high.
REQ-006 control_i  in  1  level request; batch starts on its high level in ST_RB_IDLE.
REQ-007 count_i  in  ADDR_W  number of operand pairs; sampled on start.
REQ-008 src_base_i / dst_base_i  in  ADDR_W each  operand and result base addresses; sampled on start.
REQ-009 ram_addr_o  out  ADDR_W; ram_rd_o  out  1; ram_wr_o  out  1; ram_wdata_o  out  DATA_W  RAM port.
REQ-010 ram_rdata_i  in  DATA_W  read data, valid exactly one cycle after ram_rd_o high.
REQ-011 op_a_o / op_b_o  out  DATA_W each  registered multiplier operands.
REQ-012 start_mult_o  out  1  one-cycle multiplier start pulse; end_mult_i  in  1  multiplier completion; result_i  in  2*DATA_W  product, valid while end_mult_i high and held afterwards.
REQ-013 busy_o, done_o, err_o  out  1 each; done_cnt_o  out  ADDR_W pairs completed; state_o  out  4  current state code.

Function
REQ-014 States: IDLE, READ_A, READ_B, LATCH_B, INIT_CALC, WAIT_CALC, STORE_LO, STORE_HI, NEXT, END_CALC, ERROR, WAIT_CONTROL, RESET_STATUS.
REQ-015 IDLE: control_i=1 -> READ_A (count_i>0) or END_CALC (count_i=0); else stay; pair index k cleared on start.
REQ-016 READ_A: ram_rd_o=1, ram_addr_o=src+2k. READ_B: ram_rd_o=1, ram_addr_o=src+2k+1, op_a_o<=ram_rdata_i. LATCH_B: op_b_o<=ram_rdata_i.
REQ-017 INIT_CALC: start_mult_o=1 for exactly that cycle, timeout counter cleared; next WAIT_CALC.
REQ-018 WAIT_CALC: end_mult_i=1 -> STORE_LO, result registered; else counter increments; counter reaching TIMEOUT -> ERROR; end_mult_i in the expiry cycle takes priority over timeout.
REQ-019 STORE_LO: ram_wr_o=1, addr dst+2k, wdata result[DATA_W-1:0]. STORE_HI: ram_wr_o=1, addr dst+2k+1, wdata result[2*DATA_W-1:DATA_W].
REQ-020 NEXT: done_cnt_o<=k+1; if k+1=count -> END_CALC, else k<=k+1 and -> READ_A.
REQ-021 All address arithmetic modulo 2^ADDR_W (wrap, no error).
REQ-022 END_CALC: done_o<=1 -> WAIT_CONTROL. ERROR: err_o<=1, done_o<=1 -> WAIT_CONTROL.
REQ-023 WAIT_CONTROL: stay while control_i=1; control_i=0 -> RESET_STATUS, which clears done_o, err_o -> IDLE.
REQ-024 busy_o=1 in every state except IDLE, WAIT_CONTROL, RESET_STATUS.
REQ-025 control_i deassertion mid-batch is ignored; batch runs to END_CALC or ERROR.
REQ-026 ram_rd_o, ram_wr_o, start_mult_o never high simultaneously; all three low outside their named states.
REQ-027 Undefined state code -> IDLE next cycle.

Reset
REQ-028 rst_i=1 at a clock edge forces IDLE, all outputs 0, k, counters and operand registers 0, including mid-batch; no RAM write issued in the cycle following reset.

Structure
REQ-029 Shared package multiplicador_defines holds typedef estado_ram_batch_t (4-bit enum, ST_RB_* names) alongside existing types.
REQ-030 One sub-module: controlador_ram_batch_timer (timeout counter, clear/enable in, expired out).

Verification
REQ-031 count=3, src=0x10, dst=0x40, end_mult after 5 cycles -> 6 writes to 0x40..0x45, done_cnt=3, done=1, err=0.
REQ-032 count=0, control=1 -> END_CALC next cycle, no RAM access, done=1, done_cnt=0.
REQ-033 TIMEOUT=4, end_mult never -> ERROR 4 cycles after WAIT_CALC entry, err=1, done=1, no write.
REQ-034 end_mult_i exactly on timeout cycle -> STORE_LO, err=0.
REQ-035 ADDR_W=8, dst=0xFE, count=2 -> writes to 0xFE, 0xFF, 0x00, 0x01.
REQ-036 rst_i during STORE_LO -> IDLE, outputs 0, ram_wr_o low next cycle; control held high after batch -> stays WAIT_CONTROL until released.

Source files
------------

// File: rtl/multiplicador_defines_pkg.sv
// Shared multiplier-subsystem types: state encodings and common widths.
// No logic; latency n/a.
// Backpressure n/a.
package multiplicador_defines;

  localparam int MULT_DEFAULT_W = 16;

  // Multiplier core states (existing type used by the multiplier block)
  typedef enum logic [1:0] {
    ST_M_IDLE = 2'd0,
    ST_M_CALC = 2'd1,
    ST_M_DONE = 2'd2
  } estado_mult_t;

  // RAM batch controller states
  typedef enum logic [3:0] {
    ST_RB_IDLE         = 4'd0,
    ST_RB_READ_A       = 4'd1,
    ST_RB_READ_B       = 4'd2,
    ST_RB_LATCH_B      = 4'd3,
    ST_RB_INIT_CALC    = 4'd4,
    ST_RB_WAIT_CALC    = 4'd5,
    ST_RB_STORE_LO     = 4'd6,
    ST_RB_STORE_HI     = 4'd7,
    ST_RB_NEXT         = 4'd8,
    ST_RB_END_CALC     = 4'd9,
    ST_RB_ERROR        = 4'd10,
    ST_RB_WAIT_CONTROL = 4'd11,
    ST_RB_RESET_STATUS = 4'd12
  } estado_ram_batch_t;

endpackage

// File: rtl/controlador_ram_batch_if.sv
// RAM port and multiplier handshake bundle between batch controller and its peers.
// Pure wiring, zero latency.
// No backpressure; RAM read data returns one cycle after the read strobe.
interface controlador_ram_batch_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0]   ram_addr_o;
  logic                ram_rd_o;
  logic                ram_wr_o;
  logic [DATA_W-1:0]   ram_wdata_o;
  logic [DATA_W-1:0]   ram_rdata_i;
  logic [DATA_W-1:0]   op_a_o;
  logic [DATA_W-1:0]   op_b_o;
  logic                start_mult_o;
  logic                end_mult_i;
  logic [2*DATA_W-1:0] result_i;

  modport master (
    output ram_addr_o, ram_rd_o, ram_wr_o, ram_wdata_o, op_a_o, op_b_o, start_mult_o,
    input  ram_rdata_i, end_mult_i, result_i
  );

  modport slave (
    input  ram_addr_o, ram_rd_o, ram_wr_o, ram_wdata_o, op_a_o, op_b_o, start_mult_o,
    output ram_rdata_i, end_mult_i, result_i
  );
endinterface

// File: rtl/controlador_ram_batch_timer.sv
// Multiplier watchdog: counts enabled cycles, flags the last allowed one.
// expired is combinational from the count, so it fires in cycle TIMEOUT-1 after clear.
// No backpressure; clear wins over enable.
module controlador_ram_batch_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam logic [15:0] LIMIT = 16'(TIMEOUT - 1);

  logic [15:0] cnt;

  // Count cycles spent waiting; hold once the limit is reached
  always_ff @(posedge clk_i) begin
    if (rst_i || clear) begin
      cnt <= '0;
    end else if (enable && (cnt != LIMIT)) begin
      cnt <= cnt + 16'd1;
    end
  end

  assign expired = enable && (cnt == LIMIT);
endmodule

// File: rtl/controlador_ram_batch.sv
// Batch multiply: reads operand pairs from RAM, runs the multiplier, writes 2-word products back.
// Per pair: 2 reads, 1 start, multiplier latency, 2 writes, 1 bookkeeping cycle.
// No backpressure; a silent multiplier is cut off by the timeout and the batch ends in error.
module controlador_ram_batch
  import multiplicador_defines::*;
#(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              control_i,
  input  logic [ADDR_W-1:0] count_i,
  input  logic [ADDR_W-1:0] src_base_i,
  input  logic [ADDR_W-1:0] dst_base_i,
  controlador_ram_batch_if.master bus,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [ADDR_W-1:0] done_cnt_o,
  output logic [3:0]        state_o
);
  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  estado_ram_batch_t   state;
  logic [ADDR_W-1:0]   k, count_q, src_q, dst_q, done_cnt_q, addr_q;
  logic [DATA_W-1:0]   op_a_q, op_b_q, wdata_q;
  logic [2*DATA_W-1:0] result_q;
  logic                rd_q, wr_q, start_q, done_q, err_q;
  logic                expired;
  logic [ADDR_W-1:0]   k_inc, two_k, two_k_inc;

  // Pair offsets; all address math wraps at 2^ADDR_W
  assign k_inc     = k + ONE;
  assign two_k     = {k[ADDR_W-2:0], 1'b0};
  assign two_k_inc = {k_inc[ADDR_W-2:0], 1'b0};

  controlador_ram_batch_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear   (state == ST_RB_INIT_CALC),
    .enable  (state == ST_RB_WAIT_CALC),
    .expired (expired)
  );

  // Batch FSM; strobes are registered on the transition into the state that owns them
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= ST_RB_IDLE;
      k          <= '0;
      count_q    <= '0;
      src_q      <= '0;
      dst_q      <= '0;
      done_cnt_q <= '0;
      addr_q     <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      wdata_q    <= '0;
      result_q   <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      start_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      start_q <= 1'b0;
      case (state)
        ST_RB_IDLE: begin
          if (control_i) begin
            count_q    <= count_i;
            src_q      <= src_base_i;
            dst_q      <= dst_base_i;
            k          <= '0;
            done_cnt_q <= '0;
            if (count_i != '0) begin
              rd_q   <= 1'b1;
              addr_q <= src_base_i;
              state  <= ST_RB_READ_A;
            end else begin
              state  <= ST_RB_END_CALC;
            end
          end
        end
        ST_RB_READ_A: begin
          rd_q   <= 1'b1;
          addr_q <= src_q + two_k + ONE;
          state  <= ST_RB_READ_B;
        end
        ST_RB_READ_B: begin
          op_a_q <= bus.ram_rdata_i;
          state  <= ST_RB_LATCH_B;
        end
        ST_RB_LATCH_B: begin
          op_b_q  <= bus.ram_rdata_i;
          start_q <= 1'b1;
          state   <= ST_RB_INIT_CALC;
        end
        ST_RB_INIT_CALC: state <= ST_RB_WAIT_CALC;
        ST_RB_WAIT_CALC: begin
          // a completion on the last allowed cycle still counts as success
          if (bus.end_mult_i) begin
            result_q <= bus.result_i;
            wr_q     <= 1'b1;
            addr_q   <= dst_q + two_k;
            wdata_q  <= bus.result_i[DATA_W-1:0];
            state    <= ST_RB_STORE_LO;
          end else if (expired) begin
            state    <= ST_RB_ERROR;
          end
        end
        ST_RB_STORE_LO: begin
          wr_q    <= 1'b1;
          addr_q  <= dst_q + two_k + ONE;
          wdata_q <= result_q[2*DATA_W-1:DATA_W];
          state   <= ST_RB_STORE_HI;
        end
        ST_RB_STORE_HI: state <= ST_RB_NEXT;
        ST_RB_NEXT: begin
          done_cnt_q <= k_inc;
          if (k_inc == count_q) begin
            state  <= ST_RB_END_CALC;
          end else begin
            k      <= k_inc;
            rd_q   <= 1'b1;
            addr_q <= src_q + two_k_inc;
            state  <= ST_RB_READ_A;
          end
        end
        ST_RB_END_CALC: begin
          done_q <= 1'b1;
          state  <= ST_RB_WAIT_CONTROL;
        end
        ST_RB_ERROR: begin
          err_q  <= 1'b1;
          done_q <= 1'b1;
          state  <= ST_RB_WAIT_CONTROL;
        end
        ST_RB_WAIT_CONTROL: begin
          if (!control_i) state <= ST_RB_RESET_STATUS;
        end
        ST_RB_RESET_STATUS: begin
          done_q <= 1'b0;
          err_q  <= 1'b0;
          state  <= ST_RB_IDLE;
        end
        default: state <= ST_RB_IDLE;
      endcase
    end
  end

  assign bus.ram_addr_o   = addr_q;
  assign bus.ram_rd_o     = rd_q;
  assign bus.ram_wr_o     = wr_q;
  assign bus.ram_wdata_o  = wdata_q;
  assign bus.op_a_o       = op_a_q;
  assign bus.op_b_o       = op_b_q;
  assign bus.start_mult_o = start_q;

  assign busy_o     = !((state == ST_RB_IDLE) || (state == ST_RB_WAIT_CONTROL) ||
                        (state == ST_RB_RESET_STATUS));
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign done_cnt_o = done_cnt_q;
  assign state_o    = state;
endmodule

// File: tb/tb_controlador_ram_batch.sv
// Bench for controlador_ram_batch: behavioural RAM + multiplier, transaction-level reference.
// Model predicts read/operand/write sequences and final memory per batch.
// Multiplier latency per pair is chosen by the bench; latencies above TO must end in error.
module tb_controlador_ram_batch;
  import multiplicador_defines::*;

  localparam int DW = 16;
  localparam int AW = 8;
  localparam int TO = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          control;
  logic [AW-1:0] count_i, src_base, dst_base;
  logic          busy_o, done_o, err_o;
  logic [AW-1:0] done_cnt_o;
  logic [3:0]    state_o;

  controlador_ram_batch_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  controlador_ram_batch #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst), .control_i(control), .count_i(count_i),
    .src_base_i(src_base), .dst_base_i(dst_base), .bus(bus),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .done_cnt_o(done_cnt_o), .state_o(state_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Bench RAM and multiplier
  logic [DW-1:0] mem [256];
  logic [DW-1:0] ref_mem [256];
  logic [AW-1:0] wr_log [$];
  int            n_writes;
  int            lat [256];
  int            m_cnt, start_idx;
  logic [DW-1:0] pa, pb;

  always @(posedge clk) begin
    if (bus.ram_wr_o) begin
      mem[bus.ram_addr_o] = bus.ram_wdata_o;
      wr_log.push_back(bus.ram_addr_o);
      n_writes++;
    end
    if (bus.ram_rd_o) bus.ram_rdata_i <= mem[bus.ram_addr_o];
  end

  always @(posedge clk) begin
    if (rst) begin
      bus.end_mult_i <= 1'b0;
      bus.result_i   <= '0;
      m_cnt = 0;
      start_idx = 0;
    end else begin
      bus.end_mult_i <= 1'b0;
      if (state_o == ST_RB_IDLE) start_idx = 0;
      if (bus.start_mult_o) begin
        pa = bus.op_a_o;
        pb = bus.op_b_o;
        if (lat[start_idx] <= 1) begin
          bus.end_mult_i <= 1'b1;
          bus.result_i   <= 32'(pa) * 32'(pb);
          m_cnt = 0;
        end else begin
          m_cnt = lat[start_idx] - 1;
        end
        start_idx++;
      end else if (m_cnt != 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          bus.end_mult_i <= 1'b1;
          bus.result_i   <= 32'(pa) * 32'(pb);
        end
      end
    end
  end

  // Reference: expected transaction queues and batch outcome
  logic [AW-1:0]   rd_q [$];
  logic [2*DW-1:0] op_q [$];
  logic [AW+DW-1:0] wr_q [$];
  logic            exp_err;
  int              exp_cnt;

  task automatic build_model(input int cnt, input logic [AW-1:0] src, input logic [AW-1:0] dst);
    logic [AW-1:0]   aa, ab, wa;
    logic [DW-1:0]   a, b;
    logic [2*DW-1:0] p;
    rd_q.delete(); op_q.delete(); wr_q.delete();
    ref_mem = mem;
    exp_err = 1'b0;
    exp_cnt = 0;
    for (int k = 0; k < cnt; k++) begin
      aa = AW'(src + 2 * k);
      ab = AW'(src + 2 * k + 1);
      rd_q.push_back(aa);
      rd_q.push_back(ab);
      a = ref_mem[aa];
      b = ref_mem[ab];
      op_q.push_back({a, b});
      if (lat[k] > TO) begin
        exp_err = 1'b1;
        break;
      end
      p  = 32'(a) * 32'(b);
      wa = AW'(dst + 2 * k);
      wr_q.push_back({wa, p[DW-1:0]});
      ref_mem[wa] = p[DW-1:0];
      wa = AW'(dst + 2 * k + 1);
      wr_q.push_back({wa, p[2*DW-1:DW]});
      ref_mem[wa] = p[2*DW-1:DW];
      exp_cnt = k + 1;
    end
  endtask

  // Per-cycle compare against the expected transaction streams
  int              wait_run = 0, last_wait = 0;
  logic [3:0]      last_exit = '0;
  logic [AW-1:0]   e_addr;
  logic [2*DW-1:0] e_op;
  logic [AW+DW-1:0] e_wr;

  always @(negedge clk) begin
    if (!rst) begin
      check("strobe_excl", 64'(int'(bus.ram_rd_o) + int'(bus.ram_wr_o) + int'(bus.start_mult_o) <= 1), 64'd1);
      check("busy", 64'(busy_o), 64'(!(state_o inside {ST_RB_IDLE, ST_RB_WAIT_CONTROL, ST_RB_RESET_STATUS})));
      if (bus.ram_rd_o) begin
        if (rd_q.size() == 0) check("rd_unexpected", 64'd1, 64'd0);
        else begin e_addr = rd_q.pop_front(); check("rd_addr", 64'(bus.ram_addr_o), 64'(e_addr)); end
      end
      if (bus.start_mult_o) begin
        if (op_q.size() == 0) check("start_unexpected", 64'd1, 64'd0);
        else begin e_op = op_q.pop_front(); check("operands", 64'({bus.op_a_o, bus.op_b_o}), 64'(e_op)); end
      end
      if (bus.ram_wr_o) begin
        if (wr_q.size() == 0) check("wr_unexpected", 64'd1, 64'd0);
        else begin e_wr = wr_q.pop_front(); check("wr_addr_data", 64'({bus.ram_addr_o, bus.ram_wdata_o}), 64'(e_wr)); end
      end
    end
    if (state_o == ST_RB_WAIT_CALC) wait_run++;
    else begin
      if (wait_run != 0) begin last_wait = wait_run; last_exit = state_o; end
      wait_run = 0;
    end
  end

  task automatic do_reset();
    rst = 1'b1; control = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic start_batch(input int cnt, input logic [AW-1:0] src, input logic [AW-1:0] dst);
    build_model(cnt, src, dst);
    @(negedge clk);
    control = 1'b1; count_i = AW'(cnt); src_base = src; dst_base = dst;
  endtask

  task automatic finish_batch(input int drop_at);
    bit got = 1'b0;
    int diffs = 0;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin count_i = AW'($urandom); src_base = AW'($urandom); dst_base = AW'($urandom); end
      if (cyc == drop_at) control = 1'b0;
      if (done_o) begin got = 1'b1; break; end
    end
    check("done_seen", 64'(got), 64'd1);
    if (!got) begin do_reset(); return; end
    check("err", 64'(err_o), 64'(exp_err));
    check("done_cnt", 64'(done_cnt_o), 64'(exp_cnt));
    check("queues_drained", 64'(rd_q.size() + op_q.size() + wr_q.size()), 64'd0);
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) diffs++;
    check("mem_image", 64'(diffs), 64'd0);
    if (control) begin
      repeat (3) begin
        @(negedge clk);
        check("hold_wait_control", 64'(state_o), 64'(ST_RB_WAIT_CONTROL));
      end
      control = 1'b0;
    end
    for (int cyc = 0; cyc < 10 && state_o != ST_RB_IDLE; cyc++) @(negedge clk);
    check("back_idle", 64'(state_o), 64'(ST_RB_IDLE));
    check("status_cleared", 64'({done_o, err_o}), 64'd0);
  endtask

  initial begin
    logic [15:0] exp6 [6];
    logic [AW-1:0] exp_wrap [4];
    rst = 1'b1; control = 1'b0; count_i = '0; src_base = '0; dst_base = '0;
    bus.ram_rdata_i = '0;
    n_writes = 0;
    for (int i = 0; i < 256; i++) begin mem[i] = 16'($urandom); lat[i] = 2; end
    repeat (3) @(negedge clk);
    check("rst_state", 64'(state_o), 64'(ST_RB_IDLE));
    check("rst_flags", 64'({busy_o, done_o, err_o, bus.ram_rd_o, bus.ram_wr_o, bus.start_mult_o}), 64'd0);
    check("rst_data", 64'({done_cnt_o, bus.ram_addr_o, bus.ram_wdata_o}), 64'd0);
    check("rst_ops", 64'({bus.op_a_o, bus.op_b_o}), 64'd0);
    rst = 1'b0;

    // three pairs, 5-cycle multiplier
    mem[8'h10] = 16'd3;      mem[8'h11] = 16'd5;
    mem[8'h12] = 16'h1234;   mem[8'h13] = 16'h0100;
    mem[8'h14] = 16'hFFFF;   mem[8'h15] = 16'hFFFF;
    for (int i = 0; i < 3; i++) lat[i] = 5;
    n_writes = 0;
    start_batch(3, 8'h10, 8'h40);
    finish_batch(-1);
    exp6 = '{16'h000F, 16'h0000, 16'h3400, 16'h0012, 16'h0001, 16'hFFFE};
    for (int i = 0; i < 6; i++) check("lit_product", 64'(mem[8'h40 + i]), 64'(exp6[i]));
    check("lit_nwrites", 64'(n_writes), 64'd6);

    // empty batch goes straight to END_CALC
    n_writes = 0;
    start_batch(0, 8'h22, 8'h33);
    @(negedge clk);
    check("zero_end_calc", 64'(state_o), 64'(ST_RB_END_CALC));
    finish_batch(-1);
    check("zero_nwrites", 64'(n_writes), 64'd0);

    // silent multiplier: error exactly TO cycles after entering WAIT_CALC
    n_writes = 0;
    lat[0] = TO + 3;
    start_batch(1, 8'h50, 8'h60);
    finish_batch(-1);
    check("timeout_len", 64'(last_wait), 64'(TO));
    check("timeout_exit", 64'(last_exit), 64'(ST_RB_ERROR));
    check("timeout_nwrites", 64'(n_writes), 64'd0);

    // completion on the expiry cycle wins
    lat[0] = TO;
    start_batch(1, 8'h70, 8'h78);
    finish_batch(-1);
    check("edge_len", 64'(last_wait), 64'(TO));
    check("edge_exit", 64'(last_exit), 64'(ST_RB_STORE_LO));

    // destination wraps past 0xFF
    lat[0] = 1; lat[1] = 3;
    wr_log.delete();
    start_batch(2, 8'h90, 8'hFE);
    finish_batch(-1);
    exp_wrap = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    check("wrap_count", 64'(wr_log.size()), 64'd4);
    for (int i = 0; i < 4 && i < wr_log.size(); i++) check("wrap_addr", 64'(wr_log[i]), 64'(exp_wrap[i]));

    // reset while the low word is being stored
    lat[0] = 2; lat[1] = 2;
    start_batch(2, 8'h20, 8'h80);
    for (int cyc = 0; cyc < 200 && state_o != ST_RB_STORE_LO; cyc++) @(negedge clk);
    check("reached_store_lo", 64'(state_o), 64'(ST_RB_STORE_LO));
    rst = 1'b1; control = 1'b0;
    @(negedge clk);
    check("mid_rst_state", 64'(state_o), 64'(ST_RB_IDLE));
    check("mid_rst_flags", 64'({busy_o, done_o, err_o, bus.ram_wr_o, bus.ram_rd_o, bus.start_mult_o}), 64'd0);
    check("mid_rst_regs", 64'({done_cnt_o, bus.op_a_o, bus.op_b_o}), 64'd0);
    rst = 1'b0;
    rd_q.delete(); op_q.delete(); wr_q.delete();
    @(negedge clk);

    // randomized batches, occasionally dropping control mid-batch
    for (int t = 0; t < 30; t++) begin
      int cnt;
      for (int i = 0; i < 256; i++) begin
        lat[i] = ($urandom_range(0, 9) == 0) ? TO + 1 + int'($urandom_range(0, 3)) : int'($urandom_range(1, TO));
      end
      cnt = int'($urandom_range(0, 6));
      start_batch(cnt, AW'($urandom), AW'($urandom));
      finish_batch(($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 10)) : -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
